// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the registered N:1 selector stage: select-width
// helper, stage occupancy encoding and the channel-count ceiling.
package mux_pipe_pkg;

  localparam int MAX_INPUTS = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Bits needed to index n channels, never less than one.
  function automatic int sel_bits_f(input int n);
    int bits;
    bits = 1;
    while ((1 << bits) < n) bits = bits + 1;
    return bits;
  endfunction

endpackage

// File: rtl/mux_n_1.sv
// Purely combinational N:1 word selector. Indices at or beyond NUM_INPUTS
// select an all-zero word.
module mux_n_1
  import mux_pipe_pkg::*;
#(
  parameter int DATA_BITS  = 32,
  parameter int NUM_INPUTS = 4,
  localparam int SEL_BITS  = sel_bits_f(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS*DATA_BITS-1:0] in_data,
  input  logic [SEL_BITS-1:0]             sel,
  output logic [DATA_BITS-1:0]            out_data
);

  localparam int SLOTS = 1 << SEL_BITS;

  // Padding to a power of two keeps every sel value a legal array index.
  logic [DATA_BITS-1:0] slot [SLOTS];

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NUM_INPUTS) begin : g_ch
        assign slot[gi] = in_data[gi*DATA_BITS +: DATA_BITS];
      end else begin : g_pad
        assign slot[gi] = '0;
      end
    end
  endgenerate

  assign out_data = slot[sel];

endmodule

// File: rtl/mux_pipe_n.sv
// N:1 selector feeding a registered elastic stage (main + skid register) with
// valid/ready handshake and synchronous flush. Define MUX_PIPE_SEL_CHECK_EN to
// flag beats accepted with an out-of-range sel on sel_err.
module mux_pipe_n
  import mux_pipe_pkg::*;
#(
  parameter int DATA_BITS  = 32,
  parameter int NUM_INPUTS = 4,
  localparam int SEL_BITS  = sel_bits_f(NUM_INPUTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_INPUTS*DATA_BITS-1:0] in_data,
  input  logic [SEL_BITS-1:0]             sel,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            flush,
  output logic [DATA_BITS-1:0]            out_data,
  output logic [SEL_BITS-1:0]             out_sel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            sel_err
);

  generate
    if (NUM_INPUTS < 2 || NUM_INPUTS > MAX_INPUTS) begin : g_bad_param
      $error("mux_pipe_n: NUM_INPUTS must be within 2..16");
    end
  endgenerate

  state_t               state_reg, state_next;
  logic [DATA_BITS-1:0] main_data_reg, skid_data_reg, beat_data;
  logic [SEL_BITS-1:0]  main_sel_reg, skid_sel_reg, beat_sel;
  logic                 sel_ok, accept, emit;
  logic                 load_main_in, load_main_skid, load_skid;

  assign sel_ok    = int'(sel) < NUM_INPUTS;
  assign out_valid = (state_reg != EMPTY);
  assign in_ready  = (state_reg != FULL);
  assign accept    = in_valid & in_ready & ~flush;
  assign emit      = out_valid & out_ready;
  assign out_data  = main_data_reg;
  assign out_sel   = main_sel_reg;

`ifdef MUX_PIPE_SEL_CHECK_EN
  logic main_err_reg, skid_err_reg;

  // Out-of-range sel is kept as-is; the padded selector supplies zero data.
  assign beat_sel = sel;
  assign sel_err  = out_valid & main_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_err_reg <= 1'b0;
      skid_err_reg <= 1'b0;
    end else begin
      if (load_main_in)        main_err_reg <= ~sel_ok;
      else if (load_main_skid) main_err_reg <= skid_err_reg;
      if (load_skid)           skid_err_reg <= ~sel_ok;
    end
  end
`else
  assign beat_sel = sel_ok ? sel : '0;
  assign sel_err  = 1'b0;
`endif

  mux_n_1 #(
    .DATA_BITS  (DATA_BITS),
    .NUM_INPUTS (NUM_INPUTS)
  ) u_mux (
    .in_data  (in_data),
    .sel      (beat_sel),
    .out_data (beat_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_reg)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_next   = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end else if (emit) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          load_main_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush wins over everything but leaves the data registers untouched.
    if (flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_reg <= '0;
      main_sel_reg  <= '0;
      skid_data_reg <= '0;
      skid_sel_reg  <= '0;
    end else begin
      if (load_main_in) begin
        main_data_reg <= beat_data;
        main_sel_reg  <= beat_sel;
      end else if (load_main_skid) begin
        main_data_reg <= skid_data_reg;
        main_sel_reg  <= skid_sel_reg;
      end
      if (load_skid) begin
        skid_data_reg <= beat_data;
        skid_sel_reg  <= beat_sel;
      end
    end
  end

endmodule

// File: tb/tb_mux_pipe_n.sv
// Self-checking bench for mux_pipe_n: queue-based reference of the stage
// contents, directed handshake/flush/reset cases and a randomised stream.
module tb_mux_pipe_n;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [1:0]   sel;
  logic         in_valid, in_ready, flush, out_valid, out_ready, sel_err;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;

  // Second instance: 3 channels, so sel=3 is out of range.
  logic [23:0]  d3_in_data;
  logic [1:0]   d3_sel, d3_out_sel;
  logic         d3_in_valid, d3_in_ready, d3_flush, d3_out_valid, d3_out_ready, d3_sel_err;
  logic [7:0]   d3_out_data;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  mux_pipe_n #(.DATA_BITS(32), .NUM_INPUTS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  mux_pipe_n #(.DATA_BITS(8), .NUM_INPUTS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .sel(d3_sel),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .flush(d3_flush),
    .out_data(d3_out_data), .out_sel(d3_out_sel), .out_valid(d3_out_valid),
    .out_ready(d3_out_ready), .sel_err(d3_sel_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference selection: channel s is the s-th 32-bit word of the bus.
  function automatic beat_t ref_beat(input logic [127:0] bus, input logic [1:0] s);
    beat_t b;
    b.d = 32'(bus >> (32 * int'(s)));
    b.s = s;
    return b;
  endfunction

  // Monitor: the queue holds exactly the beats the stage should be holding.
  always @(negedge clk) begin : mon
    int occ;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      occ = exp_q.size();
      check("out_valid", 32'(out_valid), 32'(occ > 0));
      check("in_ready", 32'(in_ready), 32'(occ < 2));
      check("sel_err", 32'(sel_err), 32'd0);
      if (occ > 0) begin
        check("out_data", out_data, exp_q[0].d);
        check("out_sel", 32'(out_sel), 32'(exp_q[0].s));
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (occ > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && occ < 2) exp_q.push_back(ref_beat(in_data, sel));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e3_d;
    logic [1:0] e3_s;
    logic       e3_e;

    rst_n = 1'b0; in_data = '0; sel = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    d3_in_data = {8'h33, 8'h22, 8'h11}; d3_sel = '0; d3_in_valid = 1'b0;
    d3_flush = 1'b0; d3_out_ready = 1'b1;
    cyc(); cyc();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_data", out_data, 32'd0);
    check("rst out_sel", 32'(out_sel), 32'd0);
    check("rst sel_err", 32'(sel_err), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Back-to-back stream, one-cycle latency.
    in_data = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    out_ready = 1'b1; in_valid = 1'b1;
    sel = 2'd2; cyc();
    check("stream0 data", out_data, 32'hC2); check("stream0 sel", 32'(out_sel), 32'd2);
    sel = 2'd0; cyc();
    check("stream1 data", out_data, 32'hA0); check("stream1 sel", 32'(out_sel), 32'd0);
    sel = 2'd3; cyc();
    check("stream2 data", out_data, 32'hD3); check("stream2 sel", 32'(out_sel), 32'd3);
    in_valid = 1'b0; cyc(); cyc();

    // Backpressure fills the skid register, then drains in order.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    in_data[63:32] = 32'h1111_0001; cyc();
    in_data[63:32] = 32'h2222_0002; cyc();
    check("bp in_ready full", 32'(in_ready), 32'd0);
    in_data[63:32] = 32'h3333_0003; cyc();
    in_valid = 1'b0; out_ready = 1'b1; cyc();
    check("bp in_ready after emit", 32'(in_ready), 32'd1);
    check("bp second beat", out_data, 32'h2222_0002);
    cyc(); cyc();

    // Flush while full with a concurrent offered beat.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    in_data[31:0] = 32'h4444_0004; cyc();
    in_data[31:0] = 32'h5555_0005; cyc();
    flush = 1'b1; out_ready = 1'b1; in_data[31:0] = 32'h6666_0006; cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    cyc(); cyc();

    // Asynchronous reset between clock edges while streaming.
    in_valid = 1'b1; sel = 2'd1; in_data[63:32] = 32'h7777_0007;
    cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    check("areset out_valid", 32'(out_valid), 32'd0);
    check("areset out_data", out_data, 32'd0);
    check("areset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    in_data[63:32] = 32'h8888_0008;
    cyc();
    check("post-reset data", out_data, 32'h8888_0008);
    in_valid = 1'b0; cyc(); cyc();

    // Out-of-range sel on the 3-channel instance.
`ifdef MUX_PIPE_SEL_CHECK_EN
    e3_d = 8'h00; e3_s = 2'd3; e3_e = 1'b1;
`else
    e3_d = 8'h11; e3_s = 2'd0; e3_e = 1'b0;
`endif
    d3_out_ready = 1'b0; d3_sel = 2'd3; d3_in_valid = 1'b1; cyc();
    d3_in_valid = 1'b0;
    check("oor valid", 32'(d3_out_valid), 32'd1);
    check("oor data", 32'(d3_out_data), 32'(e3_d));
    check("oor sel", 32'(d3_out_sel), 32'(e3_s));
    check("oor sel_err", 32'(d3_sel_err), 32'(e3_e));
    cyc();
    check("oor hold data", 32'(d3_out_data), 32'(e3_d));
    check("oor hold sel_err", 32'(d3_sel_err), 32'(e3_e));
    d3_out_ready = 1'b1; cyc();
    check("oor drained valid", 32'(d3_out_valid), 32'd0);
    check("oor drained sel_err", 32'(d3_sel_err), 32'd0);
    d3_sel = 2'd2; d3_in_valid = 1'b1; cyc();
    d3_in_valid = 1'b0;
    check("in-range data", 32'(d3_out_data), 32'h33);
    check("in-range sel", 32'(d3_out_sel), 32'd2);
    check("in-range sel_err", 32'(d3_sel_err), 32'd0);
    cyc();

    // Randomised handshake traffic against the queue model.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 63) == 0);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();
    check("drained", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
